// File: rtl/pcm_to_i2s_pkg.sv
// rtl/pcm_to_i2s_pkg.sv - shared parameters and slot helpers for the PCM to I2S transmitter
//
// Purpose : sample width shared with the capture path, default slot length and
//           bit-clock divider, and a helper that classifies a bit position
//           within an I2S frame.
// Ports   : none (package).
package pcm_to_i2s_pkg;

  localparam int PCM_NUMBER_OF_BITS = 8;
  localparam int PCM_SLOT_BITS      = 16;
  localparam int PCM_CLK_DIV        = 2;

  typedef enum logic [1:0] {
    REGION_LEFT,
    REGION_RIGHT,
    REGION_PAD
  } slot_region_e;

  // Which part of the frame a bit position belongs to: left data, right data
  // or zero padding at the tail of either slot.
  function automatic slot_region_e cnt_region(input int cnt, input int nbits, input int slot_bits);
    if (cnt < nbits) begin
      return REGION_LEFT;
    end else if ((cnt >= slot_bits) && (cnt < slot_bits + nbits)) begin
      return REGION_RIGHT;
    end else begin
      return REGION_PAD;
    end
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// rtl/i2s_sck_gen.sv - I2S bit clock divider with falling-edge event strobe
//
// Purpose : divides clk by 2*CLK_DIV to form sck and flags, one clk cycle ahead,
//           the edge on which sck goes 1->0 so the caller can update ws/sd on
//           that same edge.
// Ports   : i_clk    system clock, rising edge
//           i_rst_n  asynchronous active-low reset
//           o_sck    registered bit clock, resets to 0
//           o_fall   high in the cycle whose closing clk edge drives sck 1->0
module i2s_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sck,
  output logic o_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_sck;
  logic             w_wrap;

  assign w_wrap = (r_div == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (w_wrap) begin
      r_div <= '0;
      r_sck <= ~r_sck;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign o_sck  = r_sck;
  // The divider wrapping while sck is high means the next edge lowers sck.
  assign o_fall = w_wrap & r_sck;

endmodule

// File: rtl/pcm_to_i2s.sv
// rtl/pcm_to_i2s.sv - parallel left/right PCM to Philips I2S serialiser
//
// Purpose : accepts a stereo sample pair through a one-deep valid/ready holding
//           register and transmits it MSB first as a Philips I2S frame, with
//           self-generated sck and ws. Frames without a waiting sample carry
//           silence.
// Macro   : PCM_TO_I2S_UNDERRUN_EN - when defined, enables the sticky underrun
//           flag; otherwise underrun is 0 and underrun_clr is ignored.
// Ports   : clk           system clock, rising edge
//           rst_n         asynchronous active-low reset
//           pcm_left      left sample, two's complement
//           pcm_right     right sample
//           pcm_valid     producer offers {pcm_left, pcm_right}
//           pcm_ready     holding register empty
//           sck           I2S bit clock
//           ws            word select, 0 = left, 1 = right
//           sd            serial data, MSB first
//           underrun_clr  clears the sticky underrun flag
//           underrun      sticky underrun flag
module pcm_to_i2s
  import pcm_to_i2s_pkg::*;
#(
  parameter int NUMBER_OF_BITS = PCM_NUMBER_OF_BITS,
  parameter int SLOT_BITS      = PCM_SLOT_BITS,
  parameter int CLK_DIV        = PCM_CLK_DIV
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUMBER_OF_BITS-1:0] pcm_left,
  input  logic [NUMBER_OF_BITS-1:0] pcm_right,
  input  logic                      pcm_valid,
  output logic                      pcm_ready,
  output logic                      sck,
  output logic                      ws,
  output logic                      sd,
  input  logic                      underrun_clr,
  output logic                      underrun
);

  localparam int NB         = NUMBER_OF_BITS;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] WS_FIRST = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] WS_LAST  = CNT_W'(FRAME_BITS - 2);

  logic             w_fall;
  logic             w_sck;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_frame_start;
  logic             w_accept;
  slot_region_e     w_region;

  logic             r_full;
  logic [NB-1:0]    r_hold_l;
  logic [NB-1:0]    r_hold_r;
  logic [NB-1:0]    w_load_l;
  logic [NB-1:0]    w_load_r;

  logic [NB-1:0]    r_sh_l;
  logic [NB-1:0]    r_sh_r;
  logic             r_ws;
  logic             r_sd;

  i2s_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_sck   (w_sck),
    .o_fall  (w_fall)
  );

  always_comb begin
    w_cnt_next = r_cnt + CNT_W'(1);
    if (r_cnt == CNT_LAST) begin
      w_cnt_next = '0;
    end
  end

  assign w_frame_start = w_fall && (w_cnt_next == '0);
  assign w_accept      = pcm_valid && !r_full;
  assign w_region      = cnt_region(int'(w_cnt_next), NB, SLOT_BITS);

  // An empty holding register at frame start turns into a silent frame.
  // A transfer landing on the frame-start edge is not visible here, since it
  // can only happen while r_full is still low.
  assign w_load_l = r_full ? r_hold_l : '0;
  assign w_load_r = r_full ? r_hold_r : '0;

  // Holding register. Accept and frame-start load are mutually exclusive in
  // effect: accept needs it empty, the load only empties a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full   <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
    end else if (w_accept) begin
      r_full   <= 1'b1;
      r_hold_l <= pcm_left;
      r_hold_r <= pcm_right;
    end else if (w_frame_start) begin
      r_full <= 1'b0;
    end
  end

  // Bit counter, shift registers and serial outputs all move on the sck fall
  // event, so ws/sd change together with sck going low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= CNT_LAST;
      r_sh_l <= '0;
      r_sh_r <= '0;
      r_ws   <= 1'b0;
      r_sd   <= 1'b0;
    end else if (w_fall) begin
      r_cnt <= w_cnt_next;
      r_ws  <= (w_cnt_next >= WS_FIRST) && (w_cnt_next <= WS_LAST);
      if (w_frame_start) begin
        // The left MSB goes straight out; the remainder waits pre-shifted.
        r_sd   <= w_load_l[NB-1];
        r_sh_l <= w_load_l << 1;
        r_sh_r <= w_load_r;
      end else begin
        case (w_region)
          REGION_LEFT: begin
            r_sd   <= r_sh_l[NB-1];
            r_sh_l <= r_sh_l << 1;
          end
          REGION_RIGHT: begin
            r_sd   <= r_sh_r[NB-1];
            r_sh_r <= r_sh_r << 1;
          end
          default: begin
            r_sd <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PCM_TO_I2S_UNDERRUN_EN
  logic r_underrun;

  // Set takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
    end else if (w_frame_start && !r_full) begin
      r_underrun <= 1'b1;
    end else if (underrun_clr) begin
      r_underrun <= 1'b0;
    end
  end

  assign underrun = r_underrun;
`else
  logic w_unused_clr;

  assign w_unused_clr = underrun_clr;
  assign underrun     = 1'b0;
`endif

  assign pcm_ready = ~r_full;
  assign sck       = w_sck;
  assign ws        = r_ws;
  assign sd        = r_sd;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// tb/tb_pcm_to_i2s.sv - self-checking bench for pcm_to_i2s against a frame-level reference model
module tb_pcm_to_i2s;

  localparam int NB      = 8;
  localparam int SLOT    = 16;
  localparam int CLK_DIV = 2;
  localparam int FRAME   = 2 * SLOT;
  localparam int FCLK    = FRAME * 2 * CLK_DIV;

`ifdef PCM_TO_I2S_UNDERRUN_EN
  localparam bit EXP_UND = 1'b1;
`else
  localparam bit EXP_UND = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] pcm_left;
  logic [NB-1:0] pcm_right;
  logic          pcm_valid;
  logic          pcm_ready;
  logic          sck;
  logic          ws;
  logic          sd;
  logic          underrun_clr;
  logic          underrun;

  pcm_to_i2s #(
    .NUMBER_OF_BITS (NB),
    .SLOT_BITS      (SLOT),
    .CLK_DIV        (CLK_DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pcm_left     (pcm_left),
    .pcm_right    (pcm_right),
    .pcm_valid    (pcm_valid),
    .pcm_ready    (pcm_ready),
    .sck          (sck),
    .ws           (ws),
    .sd           (sd),
    .underrun_clr (underrun_clr),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model: edge count since reset release plus the sample pair that
  // each frame was started with. Everything else is derived arithmetically.
  int            m_t;
  bit            m_full;
  logic [NB-1:0] m_hl, m_hr;
  logic [NB-1:0] m_fl, m_fr;
  bit            m_und;
  bit            m_acc, m_start, m_fall;
  int            m_f;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_full = 0; m_hl = '0; m_hr = '0; m_fl = '0; m_fr = '0; m_und = 0;
    end else begin
      m_acc   = pcm_valid && !m_full;
      m_t     = m_t + 1;
      m_fall  = (m_t % (2 * CLK_DIV)) == 0;
      m_f     = m_t / (2 * CLK_DIV);
      m_start = m_fall && (((m_f - 1) % FRAME) == 0);
`ifdef PCM_TO_I2S_UNDERRUN_EN
      if (m_start && !m_full) m_und = 1;
      else if (underrun_clr)  m_und = 0;
`endif
      if (m_start) begin
        m_fl   = m_full ? m_hl : '0;
        m_fr   = m_full ? m_hr : '0;
        m_full = 0;
      end
      if (m_acc) begin
        m_full = 1;
        m_hl   = pcm_left;
        m_hr   = pcm_right;
      end
    end
  end

  function automatic int exp_cnt();
    return ((m_t / (2 * CLK_DIV)) + FRAME - 1) % FRAME;
  endfunction

  function automatic logic exp_sck();
    return ((m_t / CLK_DIV) % 2) == 1;
  endfunction

  function automatic logic exp_ws();
    int c;
    c = exp_cnt();
    return (c >= SLOT - 1) && (c <= FRAME - 2);
  endfunction

  function automatic logic exp_sd();
    int c;
    if (m_t < 2 * CLK_DIV) return 1'b0;
    c = exp_cnt();
    if (c < NB) return m_fl[NB-1-c];
    if ((c >= SLOT) && (c < SLOT + NB)) return m_fr[SLOT+NB-1-c];
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, m_t);
    end
  endtask

  task automatic check_all();
    chk("sck", {31'd0, sck}, {31'd0, exp_sck()});
    chk("ws", {31'd0, ws}, {31'd0, exp_ws()});
    chk("sd", {31'd0, sd}, {31'd0, exp_sd()});
    chk("pcm_ready", {31'd0, pcm_ready}, {31'd0, !m_full});
    chk("underrun", {31'd0, underrun}, {31'd0, m_und});
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  // Advance until the model edge count sits at the given offset in the frame.
  task automatic align(input int tgt);
    for (int i = 0; i < FCLK + 8; i++) begin
      if ((m_t % FCLK) == tgt) break;
      tick();
    end
    chk("align_timeout", m_t % FCLK, tgt);
  endtask

  logic [NB-1:0] pat_l, pat_r;
  int            c, n_xfer;

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; pcm_valid = 1'b0; pcm_left = '0; pcm_right = '0; underrun_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all();
    chk("rst_sck", sck, 0);
    chk("rst_ws", ws, 0);
    chk("rst_sd", sd, 0);
    chk("rst_ready", pcm_ready, 1);
    chk("rst_underrun", underrun, 0);

    // Free running with no producer: silence, underrun at the first frame start
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FCLK + 4; i++) begin
      tick();
      chk("idle_sd", sd, 0);
      if (m_t == 3) chk("idle_und3", underrun, 0);
      if (m_t == 4) chk("idle_und4", underrun, EXP_UND);
    end

    // Known pattern accepted on the first edge after reset release
    rst_n = 1'b0;
    pat_l = 8'hA5; pat_r = 8'h3C;
    pcm_valid = 1'b1; pcm_left = pat_l; pcm_right = pat_r;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FCLK + 8; i++) begin
      tick();
      if (m_t >= 1) pcm_valid = 1'b0;
      if (m_t == 1) chk("pat_ready", pcm_ready, 0);
      if ((m_t >= 5) && ((m_t - 5) % (2 * CLK_DIV) == 0) && (m_t < 5 + FCLK)) begin
        c = (m_t - 5) / (2 * CLK_DIV);
        if (c < NB)                          chk("pat_left", sd, pat_l[NB-1-c]);
        else if (c >= SLOT && c < SLOT + NB) chk("pat_right", sd, pat_r[SLOT+NB-1-c]);
        else                                 chk("pat_pad", sd, 0);
      end
    end

    // Producer always valid with fresh random data: one transfer per frame
    pcm_valid = 1'b1;
    pcm_left = NB'($urandom); pcm_right = NB'($urandom);
    align(4);
    n_xfer = 0;
    for (int i = 0; i < 4 * FCLK; i++) begin
      if (pcm_valid && pcm_ready) n_xfer++;
      pcm_left = NB'($urandom); pcm_right = NB'($urandom);
      tick();
    end
    chk("xfer_count", n_xfer, 4);

    // Missed frame: silence and underrun, then the late sample, then clear
    pcm_valid = 1'b0;
    align(4);
    tick();
    align(4);
    chk("miss_underrun", underrun, EXP_UND);
    repeat (10) tick();
    pcm_valid = 1'b1; pcm_left = NB'($urandom); pcm_right = NB'($urandom);
    tick();
    pcm_valid = 1'b0;
    chk("late_ready", pcm_ready, 0);
    align(4);
    repeat (FCLK - 20) tick();
    chk("late_underrun_held", underrun, EXP_UND);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    tick();
    chk("underrun_cleared", underrun, 0);

    // Reset mid-slot at cnt=5 with a sample pending
    align(10);
    pcm_valid = 1'b1; pcm_left = NB'($urandom); pcm_right = NB'($urandom);
    tick();
    pcm_valid = 1'b0;
    align(26);
    chk("mid_sck_high", sck, 1);
    chk("mid_ready_low", pcm_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_sck", sck, 0);
    chk("async_ws", ws, 0);
    chk("async_sd", sd, 0);
    chk("async_ready", pcm_ready, 1);
    chk("async_underrun", underrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FCLK + 8; i++) begin
      tick();
      chk("post_rst_sd", sd, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
